// File: rtl/ccff_ctrl_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_ctrl_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_WORD,
    ST_SHIFT,
    ST_DONE,
    ST_ERROR
  } state_e;

  // Which pass of a session is running.
  typedef enum logic {
    PASS_LOAD,
    PASS_VERIFY
  } pass_e;

  // Host words needed to cover one full pass over the chain.
  function automatic int words_per_pass(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Holds one host word and presents it MSB-first, one bit per shift.
module ccff_word_serializer #(
  parameter int WORD_W = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              clear,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] data,
  output logic              serial_out,
  output logic              last_bit
);

  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] shreg;
  logic [BIT_W-1:0]  word_bit;

  // Load a fresh word or advance to the next bit; clear drops any partial word.
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge prog_clk) begin
    if (prog_reset || clear) begin
      shreg    <= '0;
      word_bit <= '0;
    end else if (load) begin
      shreg    <= data;
      word_bit <= '0;
    end else if (shift) begin
      shreg    <= shreg << 1;
      word_bit <= word_bit + 1'b1;
    end
  end

  assign serial_out = shreg[WORD_W-1];
  assign last_bit   = (word_bit == BIT_W'(WORD_W - 1));

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises host words onto the config chain, gating prog_clk per real bit,
// with an optional read-back verify pass.
module ccff_chain_loader
  import ccff_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              verify_en,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              cfg_clk_en,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  err_index
);

  state_e           state_q, state_d;
  pass_e            pass_q, pass_d;
  logic             verify_q, verify_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] err_index_q, err_index_d;

  logic ser_load, ser_shift, ser_clear;
  logic ser_out, ser_last;
  logic pass_end;

  ccff_word_serializer #(
    .WORD_W (WORD_W)
  ) u_serializer (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .clear      (ser_clear),
    .load       (ser_load),
    .shift      (ser_shift),
    .data       (word_data),
    .serial_out (ser_out),
    .last_bit   (ser_last)
  );

  assign pass_end = (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));

  // Next-state, counter updates and state-decoded outputs.
  // Chain-facing outputs depend only on registered state, never on host inputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_d     = state_q;
    pass_d      = pass_q;
    verify_d    = verify_q;
    bit_cnt_d   = bit_cnt_q;
    err_index_d = err_index_q;
    ser_load    = 1'b0;
    ser_shift   = 1'b0;
    ser_clear   = 1'b0;
    word_ready  = 1'b0;
    cfg_clk_en  = 1'b0;
    ccff_head   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d     = ST_WAIT_WORD;
          pass_d      = PASS_LOAD;
          verify_d    = verify_en;
          bit_cnt_d   = '0;
          err_index_d = '0;
        end
      end

      ST_WAIT_WORD: begin
        word_ready = 1'b1;
        if (word_valid) begin
          ser_load = 1'b1;
          state_d  = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        cfg_clk_en = 1'b1;
        ccff_head  = ser_out;
        ser_shift  = 1'b1;
        bit_cnt_d  = bit_cnt_q + 1'b1;
        if (pass_q == PASS_VERIFY && ccff_tail != ser_out) begin
          // The mismatching bit still shifts this edge; nothing shifts after.
          err_index_d = bit_cnt_q;
          state_d     = ST_ERROR;
        end else if (pass_end) begin
          // Any unshifted bits of the current word are dropped here.
          if (pass_q == PASS_LOAD && verify_q) begin
            pass_d    = PASS_VERIFY;
            bit_cnt_d = '0;
            state_d   = ST_WAIT_WORD;
          end else begin
            state_d = ST_DONE;
          end
        end else if (ser_last) begin
          state_d = ST_WAIT_WORD;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything except reset; outputs above still reflect
    // the current state, so a SHIFT cycle completes its gate pulse.
    if (abort) begin
      state_d     = ST_IDLE;
      pass_d      = PASS_LOAD;
      verify_d    = 1'b0;
      bit_cnt_d   = '0;
      err_index_d = '0;
      ser_load    = 1'b0;
      ser_shift   = 1'b0;
      ser_clear   = 1'b1;
    end
  end

  // State, pass, counters and error index registers.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q     <= ST_IDLE;
      pass_q      <= PASS_LOAD;
      verify_q    <= 1'b0;
      bit_cnt_q   <= '0;
      err_index_q <= '0;
    end else begin
      state_q     <= state_d;
      pass_q      <= pass_d;
      verify_q    <= verify_d;
      bit_cnt_q   <= bit_cnt_d;
      err_index_q <= err_index_d;
    end
  end

  assign busy      = (state_q == ST_WAIT_WORD) || (state_q == ST_SHIFT);
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_ERROR);
  assign err_index = err_index_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: two instances (8-bit and 12-bit chains), each
// with a behavioural chain model clocked by the gated programming clock.
module tb_ccff_chain_loader;
  import ccff_ctrl_pkg::*;

  localparam int WORD_W = 8;
  localparam int CL0    = 8;
  localparam int CL1    = 12;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic             ready;
    logic             head;
    logic             en;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] erri;
    logic             tail;
  } obs_t;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic              prog_reset = 1'b1;
  logic              start0 = 1'b0, start1 = 1'b0;
  logic              verify_en = 1'b0, abort = 1'b0, word_valid = 1'b0;
  logic [WORD_W-1:0] word_data = '0;

  logic             ready0, head0, en0, busy0, done0, error0, tail0;
  logic             ready1, head1, en1, busy1, done1, error1, tail1;
  logic [CNT_W-1:0] erri0, erri1;

  ccff_chain_loader #(.CHAIN_LEN(CL0), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut0 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start0), .verify_en(verify_en),
    .abort(abort), .word_data(word_data), .word_valid(word_valid), .word_ready(ready0),
    .ccff_head(head0), .ccff_tail(tail0), .cfg_clk_en(en0), .busy(busy0), .done(done0),
    .error(error0), .err_index(erri0));

  ccff_chain_loader #(.CHAIN_LEN(CL1), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut1 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start1), .verify_en(verify_en),
    .abort(abort), .word_data(word_data), .word_valid(word_valid), .word_ready(ready1),
    .ccff_head(head1), .ccff_tail(tail1), .cfg_clk_en(en1), .busy(busy1), .done(done1),
    .error(error1), .err_index(erri1));

  // Chain models: shift only on gated clock edges; tail is the oldest bit.
  logic [CL0-1:0] chain0 = '0;
  logic [CL1-1:0] chain1 = '0;
  always @(posedge prog_clk) begin
    if (en0) chain0 <= {chain0[CL0-2:0], head0};
    if (en1) chain1 <= {chain1[CL1-2:0], head1};
  end
  assign tail0 = chain0[CL0-1];
  assign tail1 = chain1[CL1-1];

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected head bits: {is_verify_bit, head_bit}.
  logic [1:0]        exp_q[$];
  logic [WORD_W-1:0] host_q[$];
  bit                tail_chk;
  int shifts, acc_words, busy_cyc, ready_cyc;

  function automatic obs_t sample(input int sel);
    obs_t o;
    if (sel == 0) o = '{ready0, head0, en0, busy0, done0, error0, erri0, tail0};
    else          o = '{ready1, head1, en1, busy1, done1, error1, erri1, tail1};
    return o;
  endfunction

  // Advance one cycle, sample on the falling edge and score any shifted bit.
  task automatic step(input int sel, output obs_t o);
    logic [1:0] e;
    @(negedge prog_clk);
    o = sample(sel);
    if (o.en) begin
      shifts++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL head_sb: unexpected shift %0d, head=%0b", shifts, o.head);
      end else begin
        e = exp_q.pop_front();
        if (o.head !== e[0]) begin
          errors++;
          $display("FAIL head_sb: shift %0d head=%0b expected %0b", shifts, o.head, e[0]);
        end
        if (tail_chk && e[1]) begin
          checks++;
          if (o.tail !== e[0]) begin
            errors++;
            $display("FAIL verify_tail: shift %0d tail=%0b expected %0b", shifts, o.tail, e[0]);
          end
        end
      end
    end
  endtask

  // Drive one session from host_q; optionally abort/reset after kill_at shifts.
  task automatic run_session(input int sel, input bit ver, input int gap,
                             input int kill_at, input bit kill_rst, output obs_t o);
    int cl, idx, pass_bits, npass, stall, budget, n;
    bit live;
    cl = (sel == 0) ? CL0 : CL1;
    idx = 0; pass_bits = 0; npass = 0; stall = 0; budget = 500; live = 1'b1;
    shifts = 0; acc_words = 0; busy_cyc = 0; ready_cyc = 0;
    verify_en = ver;
    start0 = (sel == 0);
    start1 = (sel == 1);
    step(sel, o);
    start0 = 1'b0; start1 = 1'b0; verify_en = 1'b0;
    while (live && !(o.done || o.error)) begin
      if (budget == 0) begin
        checks++; errors++;
        $display("FAIL timeout: session on dut%0d did not finish, shifts=%0d", sel, shifts);
        live = 1'b0;
      end else if (kill_at != 0 && shifts >= kill_at) begin
        word_valid = 1'b0;
        if (kill_rst) prog_reset = 1'b1;
        else          abort = 1'b1;
        step(sel, o);
        prog_reset = 1'b0; abort = 1'b0;
        live = 1'b0;
      end else begin
        if (o.busy)  busy_cyc++;
        if (o.ready) ready_cyc++;
        if (stall > 0) begin
          word_valid = 1'b0;
          if (o.ready) begin
            stall--;
            checks++;
            if (o.en !== 1'b0) begin
              errors++;
              $display("FAIL stall_en: cfg_clk_en=%0b expected 0 during host gap", o.en);
            end
          end
        end else begin
          word_valid = (idx < host_q.size());
          if (word_valid) word_data = host_q[idx];
          if (o.ready && word_valid) begin
            n = (cl - pass_bits < WORD_W) ? cl - pass_bits : WORD_W;
            for (int b = 0; b < n; b++)
              exp_q.push_back({(ver && npass == 1), word_data[WORD_W-1-b]});
            pass_bits += n;
            if (pass_bits == cl) begin pass_bits = 0; npass++; end
            idx++;
            acc_words++;
            stall = gap;
          end
        end
        step(sel, o);
        budget--;
      end
    end
    word_valid = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    prog_reset = 1'b1;
    step(0, o);
    step(0, o);
    prog_reset = 1'b0;
    step(0, o);
    for (int s = 0; s < 2; s++) begin
      o = sample(s);
      checks++;
      if ({o.ready, o.head, o.en, o.busy, o.done, o.error, o.erri} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: dut%0d outputs=%b expected all 0", s,
                 {o.ready, o.head, o.en, o.busy, o.done, o.error, o.erri});
      end
    end
  endtask

  task automatic test_load_only();
    obs_t o;
    host_q = '{8'hA5};
    tail_chk = 1'b0;
    run_session(0, 1'b0, 0, 0, 1'b0, o);
    checks++; if (o.done !== 1'b1) begin errors++; $display("FAIL load_done: got %0b expected 1", o.done); end
    checks++; if (ready_cyc != 1) begin errors++; $display("FAIL load_ready_cycles: got %0d expected 1", ready_cyc); end
    checks++; if (shifts != 8) begin errors++; $display("FAIL load_shifts: got %0d expected 8", shifts); end
    checks++; if (busy_cyc != 9) begin errors++; $display("FAIL load_latency: got %0d expected 9", busy_cyc); end
    checks++; if (chain0 !== 8'hA5) begin errors++; $display("FAIL load_chain: got %h expected a5", chain0); end
  endtask

  task automatic test_verify_pass();
    obs_t o;
    host_q = '{8'hA5, 8'hA5};
    tail_chk = 1'b1;
    run_session(0, 1'b1, 0, 0, 1'b0, o);
    checks++; if (o.done !== 1'b1 || o.error !== 1'b0) begin errors++; $display("FAIL verify_ok: done=%0b error=%0b expected 1/0", o.done, o.error); end
    checks++; if (busy_cyc != 18) begin errors++; $display("FAIL verify_latency: got %0d expected 18", busy_cyc); end
    checks++; if (chain0 !== 8'hA5) begin errors++; $display("FAIL verify_chain: got %h expected a5", chain0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL verify_sb_left: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_verify_mismatch();
    obs_t o;
    host_q = '{8'hA5, 8'hA4};
    tail_chk = 1'b0;
    run_session(0, 1'b1, 0, 0, 1'b0, o);
    checks++; if (o.error !== 1'b1 || o.done !== 1'b0) begin errors++; $display("FAIL mismatch_flags: error=%0b done=%0b expected 1/0", o.error, o.done); end
    checks++; if (o.erri !== 4'd7) begin errors++; $display("FAIL mismatch_index: got %0d expected 7", o.erri); end
    step(0, o);
    step(0, o);
    checks++; if (o.en !== 1'b0 || o.error !== 1'b1) begin errors++; $display("FAIL mismatch_hold: en=%0b error=%0b expected 0/1", o.en, o.error); end
    checks++; if (shifts != 16) begin errors++; $display("FAIL mismatch_shifts: got %0d expected 16", shifts); end
  endtask

  task automatic test_partial_word();
    obs_t o;
    host_q = '{8'hFF, 8'h0F};
    tail_chk = 1'b0;
    run_session(1, 1'b0, 0, 0, 1'b0, o);
    checks++; if (o.done !== 1'b1) begin errors++; $display("FAIL partial_done: got %0b expected 1", o.done); end
    checks++; if (shifts != 12) begin errors++; $display("FAIL partial_shifts: got %0d expected 12", shifts); end
    checks++; if (acc_words != words_per_pass(CL1, WORD_W)) begin errors++; $display("FAIL partial_words: got %0d expected 2", acc_words); end
    checks++; if (chain1 !== 12'hFF0) begin errors++; $display("FAIL partial_chain: got %h expected ff0", chain1); end
    checks++; if (busy_cyc != 14) begin errors++; $display("FAIL partial_latency: got %0d expected 14", busy_cyc); end
  endtask

  task automatic test_host_stall();
    obs_t o;
    host_q = '{8'h3C, 8'hA7};
    tail_chk = 1'b0;
    run_session(1, 1'b0, 5, 0, 1'b0, o);
    checks++; if (o.done !== 1'b1) begin errors++; $display("FAIL stall_done: got %0b expected 1", o.done); end
    checks++; if (chain1 !== 12'h3CA) begin errors++; $display("FAIL stall_chain: got %h expected 3ca", chain1); end
    checks++; if (busy_cyc != 19) begin errors++; $display("FAIL stall_latency: got %0d expected 19", busy_cyc); end
  endtask

  task automatic test_abort_reset();
    obs_t o;
    // Abort on the third load shift.
    host_q = '{8'hA5};
    tail_chk = 1'b0;
    run_session(0, 1'b0, 0, 3, 1'b0, o);
    checks++;
    if ({o.ready, o.head, o.en, o.busy, o.done, o.error, o.erri} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got %b expected all 0", {o.ready, o.head, o.en, o.busy, o.done, o.error, o.erri});
    end
    exp_q.delete();
    run_session(0, 1'b0, 0, 0, 1'b0, o);
    checks++; if (o.done !== 1'b1 || chain0 !== 8'hA5) begin errors++; $display("FAIL abort_restart: done=%0b chain=%h expected 1/a5", o.done, chain0); end
    // Reset two shifts into the verify pass.
    host_q = '{8'h5A, 8'h5A};
    tail_chk = 1'b1;
    run_session(0, 1'b1, 0, 10, 1'b1, o);
    checks++;
    if ({o.ready, o.head, o.en, o.busy, o.done, o.error, o.erri} !== '0) begin
      errors++;
      $display("FAIL reset_mid_verify: got %b expected all 0", {o.ready, o.head, o.en, o.busy, o.done, o.error, o.erri});
    end
    exp_q.delete();
    run_session(0, 1'b1, 0, 0, 1'b0, o);
    checks++; if (o.done !== 1'b1 || o.error !== 1'b0 || chain0 !== 8'h5A) begin
      errors++;
      $display("FAIL reset_restart: done=%0b error=%0b chain=%h expected 1/0/5a", o.done, o.error, chain0);
    end
  endtask

  initial begin
    test_reset();
    test_load_only();
    test_verify_pass();
    test_verify_mismatch();
    test_partial_word();
    test_host_stall();
    test_abort_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Sequences the configuration-chain (ccff) programming of an I/O grid tile column.
- Takes bitstream words from a host over a valid/ready interface and serialises them onto `ccff_head`. Emits a per-cycle shift enable that drives the top-level `prog_clk` clock gate, so the chain only advances on real bits.
- Optional verify pass: the host re-sends the identical stream, and each bit arriving at `ccff_tail` is compared with the bit entering `ccff_head`. A passing verify leaves the configuration intact.

Parameters:
- CHAIN_LEN, default 8: total config bits in the chain (one per I/O subtile in the default tile).
- WORD_W, default 8: host word width.
- CNT_W, default $clog2(CHAIN_LEN+1): width of the bit counter and of `err_index`.

Ports:
- prog_clk  in  1  programming clock; all state on rising edge.
- prog_reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a programming session (accepted in IDLE, DONE, ERROR).
- verify_en  in  1  sampled with `start`; 1 = run a verify pass after the load pass.
- abort  in  1  synchronous abort to IDLE; highest priority after reset.
- word_data  in  WORD_W  bitstream word; MSB is shifted first.
- word_valid  in  1  host word valid.
- word_ready  out  1  loader ready for a word.
- ccff_head  out  1  serial config bit into the chain.
- ccff_tail  in  1  chain output, for verify.
- cfg_clk_en  out  1  gate enable: 1 = chain shifts at the next `prog_clk` edge.
- busy  out  1  session in progress.
- done  out  1  session completed without error (level).
- error  out  1  verify mismatch (level).
- err_index  out  CNT_W  bit index (0-based, within the pass) of the first mismatch.

Behaviour:
- Reset / abort:
  - state=IDLE; all outputs 0; counters and shift register cleared.
  - `abort` during SHIFT deasserts `cfg_clk_en` in the following cycle; the chain content is then undefined.
- States: IDLE, WAIT_WORD, SHIFT, DONE, ERROR. A `pass` flag (LOAD/VERIFY) is held alongside the state.
- IDLE/DONE/ERROR on `start`:
  - pass=LOAD; latch `verify_en`.
  - bit_cnt=0; clear done, error, err_index.
  - Go to WAIT_WORD.
  - `start` in WAIT_WORD or SHIFT is ignored.
- WAIT_WORD:
  - `word_ready`=1.
  - On `word_valid` & `word_ready`: shreg<=word_data; word_bit=0; go to SHIFT.
  - `word_ready` is 0 in every other state (so no double-accept).
- SHIFT, each cycle:
  - `cfg_clk_en`=1 and `ccff_head`=shreg[WORD_W-1].
  - At the edge: shreg shifts left; bit_cnt++; word_bit++.
  - `cfg_clk_en` and `ccff_head` are derived from registered state only (no combinational path from host inputs).
- Pass end (bit_cnt==CHAIN_LEN-1 in SHIFT):
  - Any remaining bits of the current word are discarded.
  - If pass==LOAD and verify is latched: pass=VERIFY; bit_cnt=0; go to WAIT_WORD.
  - Otherwise go to DONE.
- Word end (word_bit==WORD_W-1 and not pass end): go to WAIT_WORD.
- Words per pass = ceil(CHAIN_LEN/WORD_W).
- Verify:
  - In SHIFT with pass==VERIFY, compare `ccff_tail` against `ccff_head` in the same cycle.
  - On mismatch: error<=1; err_index<=bit_cnt; go to ERROR. The shift in that cycle still occurs; no further shifts follow.
  - A mismatch on the last bit still goes to ERROR, not DONE.
- Outputs by state:
  - `busy`=1 in WAIT_WORD and SHIFT.
  - `done`=1 only in DONE.
  - `error`=1 only in ERROR.
- Timing: no pipeline. With `word_valid` held high, the load pass takes CHAIN_LEN + ceil(CHAIN_LEN/WORD_W) cycles.
- Host stall: in WAIT_WORD, `cfg_clk_en`=0 and the chain holds.

Decomposition:
- Shared package `ccff_ctrl_pkg`:
  - state enum (IDLE, WAIT_WORD, SHIFT, DONE, ERROR);
  - pass enum (LOAD, VERIFY);
  - a function for words-per-pass.
- Sub-module `ccff_word_serializer`:
  - WORD_W shift register plus word_bit counter;
  - ports: load, shift, data in, serial out, last-bit flag.
- The FSM and the bit counter stay in the top module.

Test Plan:
1. CHAIN_LEN=8, WORD_W=8, verify_en=0, word 8'hA5 → `word_ready` for 1 cycle, then 8 `cfg_clk_en` cycles with `ccff_head` = 1,0,1,0,0,1,0,1; `done`=1; chain model holds A5.
2. verify_en=1, A5 sent twice, bench chain model is an 8-deep shift register on gated `prog_clk` → `ccff_tail`==`ccff_head` every verify cycle; `done`=1; `error`=0; total 18 cycles with `word_valid` held.
3. verify_en=1, second word 8'hA4 → mismatch at bit 7: `error`=1, `err_index`=7, `done`=0, `cfg_clk_en`=0 afterwards.
4. CHAIN_LEN=12, WORD_W=8, words 8'hFF, 8'h0F → 12 shifts (8 ones, then 0,0,0,0), the low nibble of the second word is discarded, `done` asserts, 2 words accepted.
5. `word_valid` low for 5 cycles between words → `cfg_clk_en`=0 throughout the gap, no bit lost, final chain content correct.
6. `abort` asserted at the 3rd shift of the load pass, and `prog_reset` mid-verify → state IDLE next cycle, all outputs 0; a subsequent `start` completes normally.
